// File: rtl/demux16b2_buf_pkg.sv
// ============================================================================
// demux16b2_pkg : shared constants and helpers for the 1:2 buffered demux
// Rev 1.0
// ============================================================================
`default_nettype none

package demux16b2_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux16b2_buf_if.sv
// ============================================================================
// demux16b2_buf_if : input stream plus two output channel handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

interface demux16b2_buf_if
    import demux16b2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
);
    localparam int CW = cnt_w(DEPTH);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             S;

    logic             A_VALID;
    logic             A_READY;
    logic [WIDTH-1:0] A_DATA;
    logic [CW-1:0]    A_CNT;

    logic             B_VALID;
    logic             B_READY;
    logic [WIDTH-1:0] B_DATA;
    logic [CW-1:0]    B_CNT;

    // Producer and consumers drive this side.
    modport master (
        output IN_VALID, IN_DATA, S, A_READY, B_READY,
        input  IN_READY, A_VALID, A_DATA, A_CNT, B_VALID, B_DATA, B_CNT
    );

    // The demux itself.
    modport slave (
        input  IN_VALID, IN_DATA, S, A_READY, B_READY,
        output IN_READY, A_VALID, A_DATA, A_CNT, B_VALID, B_DATA, B_CNT
    );

endinterface

`default_nettype wire

// File: rtl/demux16b2_buf_chan_fifo.sv
// ============================================================================
// chan_fifo : small per-channel FIFO with occupancy count and zeroed empty head
// Rev 1.0
// ============================================================================
`default_nettype none

module chan_fifo
    import demux16b2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  wire logic                    CLK,
    input  wire logic                    RST_N,
    input  wire logic                    push,
    input  wire logic [WIDTH-1:0]        push_data,
    input  wire logic                    pop,
    output logic                         full,
    output logic                         valid,
    output logic [WIDTH-1:0]             head,
    output logic [cnt_w(DEPTH)-1:0]      cnt
);

    localparam int            AW     = $clog2(DEPTH);
    localparam int            CW     = cnt_w(DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    logic w_push;
    logic w_pop;

    assign full   = (r_cnt == C_FULL);
    assign valid  = (r_cnt != '0);
    assign cnt    = r_cnt;
    assign head   = valid ? r_mem[r_rd_ptr] : '0;

    // Guard locally so a stray push at full or pop at empty cannot corrupt state.
    assign w_push = push && !full;
    assign w_pop  = pop && valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/demux16b2_buf.sv
// ============================================================================
// demux16b2_buf : steers one word stream into channel A or B FIFOs by S
// Rev 1.0
// ============================================================================
`default_nettype none

module demux16b2_buf
    import demux16b2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    demux16b2_buf_if.slave     bus
);

    logic w_a_full;
    logic w_b_full;
    logic w_accept;
    logic w_push_a;
    logic w_push_b;
    logic w_pop_a;
    logic w_pop_b;

    // Ready depends only on S and registered occupancy, never on consumer ready.
    assign bus.IN_READY = (bus.S == SEL_A) ? !w_a_full : !w_b_full;

    assign w_accept = bus.IN_VALID && bus.IN_READY;
    assign w_push_a = w_accept && (bus.S == SEL_A);
    assign w_push_b = w_accept && (bus.S == SEL_B);
    assign w_pop_a  = bus.A_VALID && bus.A_READY;
    assign w_pop_b  = bus.B_VALID && bus.B_READY;

    chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chan_a (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (w_push_a),
        .push_data (bus.IN_DATA),
        .pop       (w_pop_a),
        .full      (w_a_full),
        .valid     (bus.A_VALID),
        .head      (bus.A_DATA),
        .cnt       (bus.A_CNT)
    );

    chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chan_b (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (w_push_b),
        .push_data (bus.IN_DATA),
        .pop       (w_pop_b),
        .full      (w_b_full),
        .valid     (bus.B_VALID),
        .head      (bus.B_DATA),
        .cnt       (bus.B_CNT)
    );

endmodule

`default_nettype wire

// File: tb/tb_demux16b2_buf.sv
// ============================================================================
// tb_demux16b2_buf : directed stimulus, queue model compared every cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_demux16b2_buf;

    localparam int W = 16;
    localparam int D = 2;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    demux16b2_buf_if #(.WIDTH(W), .DEPTH(D)) bus ();

    demux16b2_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each channel is a bounded queue; a word is taken only if its queue has room.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            bit pa, pb, acc;
            logic [W-1:0] d;
            pa  = (qa.size() != 0) && bus.A_READY;
            pb  = (qb.size() != 0) && bus.B_READY;
            acc = bus.IN_VALID && (bus.S ? (qb.size() < D) : (qa.size() < D));
            d   = bus.IN_DATA;
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (acc) begin
                if (bus.S) qb.push_back(d);
                else       qa.push_back(d);
            end
        end
    end

    always @(negedge clk) begin
        chk("a_valid",  32'(bus.A_VALID), 32'(qa.size() != 0));
        chk("a_data",   32'(bus.A_DATA),  (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
        chk("a_cnt",    32'(bus.A_CNT),   32'(qa.size()));
        chk("b_valid",  32'(bus.B_VALID), 32'(qb.size() != 0));
        chk("b_data",   32'(bus.B_DATA),  (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
        chk("b_cnt",    32'(bus.B_CNT),   32'(qb.size()));
        chk("in_ready", 32'(bus.IN_READY),
            32'(bus.S ? (qb.size() < D) : (qa.size() < D)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
        bus.IN_VALID = v;
        bus.S        = s;
        bus.IN_DATA  = d;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.A_READY = 1'b0;
        bus.B_READY = 1'b0;
        drive(1'b0, 1'b0, '0);
        repeat (2) step();
        chk("rst_a_valid", 32'(bus.A_VALID), 32'd0);
        chk("rst_b_cnt",   32'(bus.B_CNT),   32'd0);
        chk("rst_b_data",  32'(bus.B_DATA),  32'd0);
        rst_n = 1'b1;
        step();

        // Single word to B, consumer stalled.
        drive(1'b1, 1'b1, 16'hAAAA);
        step();
        drive(1'b0, 1'b1, '0);
        chk("t1_b_valid", 32'(bus.B_VALID), 32'd1);
        chk("t1_b_data",  32'(bus.B_DATA),  32'h0000AAAA);
        chk("t1_b_cnt",   32'(bus.B_CNT),   32'd1);
        chk("t1_a_valid", 32'(bus.A_VALID), 32'd0);
        chk("t1_a_cnt",   32'(bus.A_CNT),   32'd0);
        bus.B_READY = 1'b1;
        step();
        bus.B_READY = 1'b0;

        // Fill A, check ready per select, then drain in order.
        drive(1'b1, 1'b0, 16'h0000);
        step();
        drive(1'b1, 1'b0, 16'hFFFF);
        step();
        drive(1'b0, 1'b0, '0);
        chk("t2_a_cnt",    32'(bus.A_CNT),    32'd2);
        chk("t2_rdy_s0",   32'(bus.IN_READY), 32'd0);
        bus.S = 1'b1;
        #1;
        chk("t2_rdy_s1",   32'(bus.IN_READY), 32'd1);
        bus.S = 1'b0;
        bus.A_READY = 1'b1;
        chk("t2_head0",    32'(bus.A_DATA),   32'h00000000);
        step();
        chk("t2_head1",    32'(bus.A_DATA),   32'h0000FFFF);
        step();
        chk("t2_empty",    32'(bus.A_VALID),  32'd0);
        bus.A_READY = 1'b0;

        // B full: third word held off one cycle while the consumer frees a slot.
        drive(1'b1, 1'b1, 16'hB0B0);
        step();
        drive(1'b1, 1'b1, 16'h1234);
        step();
        drive(1'b1, 1'b1, 16'hFFFF);
        bus.B_READY = 1'b1;
        chk("t3_full_rdy", 32'(bus.IN_READY), 32'd0);
        step();
        chk("t3_head1",    32'(bus.B_DATA),   32'h00001234);
        chk("t3_cnt1",     32'(bus.B_CNT),    32'd1);
        step();
        drive(1'b0, 1'b1, '0);
        chk("t3_head2",    32'(bus.B_DATA),   32'h0000FFFF);
        step();
        chk("t3_empty",    32'(bus.B_VALID),  32'd0);

        // Alternating select with both consumers always ready.
        bus.A_READY = 1'b1;
        begin
            logic [W-1:0] words [4];
            words = '{16'hAAAA, 16'hB0B0, 16'h0000, 16'hFFFF};
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, i[0], words[i]);
                step();
                if (i[0]) chk("t4_b_data", 32'(bus.B_DATA), 32'(words[i]));
                else      chk("t4_a_data", 32'(bus.A_DATA), 32'(words[i]));
            end
        end
        drive(1'b0, 1'b0, '0);
        step();
        bus.A_READY = 1'b0;
        bus.B_READY = 1'b0;

        // Simultaneous push and pop on A at count 1.
        drive(1'b1, 1'b0, 16'h5A5A);
        step();
        drive(1'b1, 1'b0, 16'hC3C3);
        bus.A_READY = 1'b1;
        step();
        drive(1'b0, 1'b0, '0);
        chk("t5_cnt",  32'(bus.A_CNT),  32'd1);
        chk("t5_data", 32'(bus.A_DATA), 32'h0000C3C3);
        step();
        bus.A_READY = 1'b0;

        // Asynchronous reset with both channels occupied.
        drive(1'b1, 1'b0, 16'h1111);
        step();
        drive(1'b1, 1'b1, 16'h2222);
        step();
        drive(1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_a_valid", 32'(bus.A_VALID), 32'd0);
        chk("t6_b_valid", 32'(bus.B_VALID), 32'd0);
        chk("t6_a_cnt",   32'(bus.A_CNT),   32'd0);
        chk("t6_b_data",  32'(bus.B_DATA),  32'd0);
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 16'h5555);
        step();
        drive(1'b0, 1'b0, '0);
        chk("t6_first", 32'(bus.A_DATA), 32'h00005555);
        bus.A_READY = 1'b1;
        step();
        chk("t6_drain", 32'(bus.A_VALID), 32'd0);
        bus.A_READY = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux16b2_buf.md
Name: demux16b2_buf

Overview:
- Inverse of the 16-bit 2:1 datapath mux: steers one 16-bit input word stream to one of two output channels (A or B), selected per word by S.
- Each output channel holds a small FIFO and uses a valid/ready handshake, so producer and consumers can stall independently.
- Sits between a single result source (e.g. ALU/memory read bus) and two consumers (e.g. register write port and I/O port).

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  input word present.
- IN_READY  output  1  selected channel can accept the word.
- IN_DATA  input  WIDTH  input word.
- S  input  1  destination select: 0 = channel A, 1 = channel B. Must be stable while IN_VALID is high.
- A_VALID  output  1  channel A head entry valid.
- A_READY  input  1  channel A consumer accepts.
- A_DATA  output  WIDTH  channel A head word.
- A_CNT  output  $clog2(DEPTH)+1  channel A occupancy.
- B_VALID  output  1  channel B head entry valid.
- B_READY  input  1  channel B consumer accepts.
- B_DATA  output  WIDTH  channel B head word.
- B_CNT  output  $clog2(DEPTH)+1  channel B occupancy.

Behaviour:
- Reset (RST_N low, async): both FIFOs empty, pointers 0, A_CNT = B_CNT = 0, A_VALID = B_VALID = 0, A_DATA = B_DATA = 0.
- Reset mid-operation discards all buffered words. No output pulses on reset release.
- IN_READY = (S==0) ? (A_CNT != DEPTH) : (B_CNT != DEPTH).
  - Combinational from S and registered counts only; no combinational path from A_READY/B_READY.
- Push:
  - Occurs when IN_VALID && IN_READY; the word goes to the channel selected by S.
  - The unselected channel is never written.
- Pop: X_VALID && X_READY removes the head entry of channel X.
- X_VALID = (X_CNT != 0). X_DATA = head entry, or 0 when empty.
- Latency: a word accepted at edge k into an empty channel appears on X_DATA/X_VALID after edge k, i.e. 1 cycle.
- Ordering: strict FIFO order per channel. No ordering relation between channels.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
  - When full, IN_READY is low, so there is no same-cycle pass-through at full.
- Simultaneous activity on both channels (push to one, pops on both) is legal; each count updates independently.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH, never exceeded.
- Pop when empty is impossible (VALID low); a READY asserted while empty is ignored.
- IN_VALID low: no push regardless of S.

Decomposition:
- Package demux16b2_pkg:
  - WIDTH_DEF = 16.
  - SEL_A = 1'b0, SEL_B = 1'b1.
- Sub-module chan_fifo (parameters WIDTH, DEPTH; ports CLK, RST_N, push, push_data, pop, full, valid, head, cnt), instantiated once per channel.
- Top level holds only steering, IN_READY generation and handshake decode.

Test Plan:
- Reset, then IN_DATA=16'hAAAA, S=1, IN_VALID=1 for one cycle, B_READY=0 -> next cycle B_VALID=1, B_DATA=16'hAAAA, B_CNT=1; A_VALID=0, A_CNT=0.
- Push 16'h0000 (S=0), then 16'hFFFF (S=0), A_READY=0 -> A_CNT=2, IN_READY=0 while S=0, IN_READY=1 with S=1; A_READY=1 -> A_DATA 16'h0000 then 16'hFFFF, then A_VALID=0.
- Channel B full (16'hB0B0, 16'h1234); present third word 16'hFFFF with S=1 and B_READY=1 in the same cycle -> not accepted that cycle (IN_READY=0); accepted next cycle; output order B0B0, 1234, FFFF.
- Alternate S every cycle with 16'hAAAA, 16'hB0B0, 16'h0000, 16'hFFFF and both READY=1 -> A receives AAAA, 0000; B receives B0B0, FFFF; each appears 1 cycle after acceptance.
- With A_CNT=1, push to A and pop A in the same cycle -> A_CNT stays 1, A_DATA advances to the new word.
- Assert RST_N=0 asynchronously (mid-cycle) with both channels non-empty -> immediately A_VALID=B_VALID=0, counts 0, data 0; after release, first push of 16'h5555 emerges first.
